// File: rtl/axis_route_tagger_pkg.sv
// axis_route_tagger_pkg: shared widths, route word and tagged-beat types for the switch ingress path.
package axis_route_tagger_pkg;

    localparam int AXI_DATA_BITS = 512;
    localparam int AXI_KEEP_BITS = AXI_DATA_BITS / 8;
    localparam int AXI_PID_BITS  = 6;
    localparam int ROUTE_BITS    = 14;

    typedef logic [ROUTE_BITS-1:0] route_t;

    localparam route_t ROUTE_RESET = 14'b00101111111100;

    typedef struct packed {
        logic [AXI_DATA_BITS-1:0] tdata;
        logic [AXI_KEEP_BITS-1:0] tkeep;
        logic                     tlast;
        logic [AXI_PID_BITS-1:0]  tid;
        route_t                   tdest;
    } tag_beat_t;

    typedef enum logic {IDLE, IN_PKT} pkt_state_t;

    // A route may change only between packets: idle with nothing arriving, or on a tlast accept.
    function automatic logic at_boundary(input pkt_state_t st, input logic acc, input logic last);
        return (st == IDLE && !acc) || (acc && last);
    endfunction

endpackage

// File: rtl/axis_skid_tag.sv
// axis_skid_tag: 2-entry registered skid buffer; output driven only from registers.
module axis_skid_tag
    import axis_route_tagger_pkg::*;
#(
    parameter type T = tag_beat_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic sk_valid;
    T     sk_data;
    logic push;

    // The skid slot is only ever occupied while the output slot is, so it alone marks full.
    assign in_ready = !sk_valid;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sk_valid  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= sk_valid || push;
            out_data  <= sk_valid ? sk_data : in_data;
            sk_valid  <= 1'b0;
        end else if (push) begin
            sk_valid <= 1'b1;
            sk_data  <= in_data;
        end
    end

endmodule

// File: rtl/axis_route_tagger.sv
// axis_route_tagger: tags a user AXI4-Stream with a route word (tdest) that changes only on packet boundaries.
module axis_route_tagger #(
    parameter int DATA_BITS = axis_route_tagger_pkg::AXI_DATA_BITS,
    parameter int ROUTE_BITS = axis_route_tagger_pkg::ROUTE_BITS,
    parameter int PID_BITS = axis_route_tagger_pkg::AXI_PID_BITS,
    parameter logic [ROUTE_BITS-1:0] ROUTE_RESET = axis_route_tagger_pkg::ROUTE_RESET
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [ROUTE_BITS-1:0]  route_cfg,
    input  logic                   route_cfg_valid,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [PID_BITS-1:0]    s_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [PID_BITS-1:0]    m_axis_tid,
    output logic [ROUTE_BITS-1:0]  m_axis_tdest,
    output logic [ROUTE_BITS-1:0]  route_act,
    output logic                   cfg_applied,
    output logic [31:0]            pkt_cnt
);
    import axis_route_tagger_pkg::*;

    pkt_state_t state;
    route_t     pend;
    route_t     eff;
    logic       pend_vld;
    logic       eff_vld;
    logic       route_set;
    logic       open;
    logic       skid_ready;
    logic       acc;
    logic       apply;
    tag_beat_t  in_beat;
    tag_beat_t  out_beat;

    // Input stays back-pressured until a first route exists, except to finish a packet in flight.
    assign open          = state == IN_PKT || route_set;
    assign s_axis_tready = skid_ready && open;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign eff           = route_cfg_valid ? route_cfg : pend;
    assign eff_vld       = route_cfg_valid || pend_vld;
    assign apply         = eff_vld && at_boundary(state, acc, s_axis_tlast);

    assign in_beat = '{
        tdata: s_axis_tdata,
        tkeep: s_axis_tkeep,
        tlast: s_axis_tlast,
        tid:   s_axis_tid,
        tdest: route_act
    };

    axis_skid_tag #(.T(tag_beat_t)) u_skid (
        .clk       (aclk),
        .rst       (areset),
        .in_valid  (s_axis_tvalid && open),
        .in_ready  (skid_ready),
        .in_data   (in_beat),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (out_beat)
    );

    assign m_axis_tdata = out_beat.tdata;
    assign m_axis_tkeep = out_beat.tkeep;
    assign m_axis_tlast = out_beat.tlast;
    assign m_axis_tid   = out_beat.tid;
    assign m_axis_tdest = out_beat.tdest;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            pend        <= ROUTE_RESET;
            pend_vld    <= 1'b0;
            route_set   <= 1'b0;
            route_act   <= ROUTE_RESET;
            cfg_applied <= 1'b0;
            pkt_cnt     <= 32'd0;
        end else begin
            if (acc)
                state <= s_axis_tlast ? IDLE : IN_PKT;
            cfg_applied <= apply;
            if (apply) begin
                route_act <= eff;
                pend_vld  <= 1'b0;
                route_set <= 1'b1;
            end else if (route_cfg_valid) begin
                pend     <= route_cfg;
                pend_vld <= 1'b1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_route_tagger.sv
// tb_axis_route_tagger: directed vectors for boundary-gated route tagging through the skid buffer.
module tb_axis_route_tagger;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [13:0]  route_cfg = '0;
    logic         route_cfg_valid = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [511:0] s_axis_tdata = '0;
    logic [63:0]  s_axis_tkeep = '0;
    logic         s_axis_tlast = 1'b0;
    logic [5:0]   s_axis_tid = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [5:0]   m_axis_tid;
    logic [13:0]  m_axis_tdest;
    logic [13:0]  route_act;
    logic         cfg_applied;
    logic [31:0]  pkt_cnt;

    typedef struct packed {
        logic [31:0] seq;
        logic        last;
        logic [13:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_applied = 0;
    int          n_rx = 0;
    logic        rnd = 1'b0;
    logic        prev_stall = 1'b0;
    logic [60:0] prev_sig = '0;
    logic [60:0] m_sig;

    always #5 aclk = ~aclk;

    axis_route_tagger dut (
        .aclk            (aclk),
        .areset          (areset),
        .route_cfg       (route_cfg),
        .route_cfg_valid (route_cfg_valid),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tid      (s_axis_tid),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tdest    (m_axis_tdest),
        .route_act       (route_act),
        .cfg_applied     (cfg_applied),
        .pkt_cnt         (pkt_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    assign m_sig = {m_axis_tdata[31:0], m_axis_tkeep[7:0], m_axis_tlast, m_axis_tid, m_axis_tdest};

    // Output monitor: scoreboard pops on every m handshake, and stalled beats must hold.
    always @(negedge aclk) begin : mon
        exp_t e;
        if (!areset) begin
            if (cfg_applied)
                n_applied++;
            if (prev_stall)
                check("stall_hold", 64'({m_axis_tvalid, m_sig}), 64'({1'b1, prev_sig}));
            if (m_axis_tvalid && m_axis_tready) begin
                n_rx++;
                if (exp_q.size() == 0)
                    check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("tdata", {m_axis_tdata[511:480], m_axis_tdata[31:0]}, {e.seq, e.seq});
                    check("tkeep", 64'(m_axis_tkeep[15:0]), 64'({e.seq[7:0], e.seq[7:0]}));
                    check("tid", 64'(m_axis_tid), 64'(e.seq[5:0]));
                    check("tlast", 64'(m_axis_tlast), 64'(e.last));
                    check("tdest", 64'(m_axis_tdest), 64'(e.tag));
                end
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready && !areset;
        prev_sig   = m_sig;
    end

    always begin
        @(posedge aclk);
        #1;
        if (rnd)
            m_axis_tready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_beat(input int seq, input logic last);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {16{32'(seq)}};
        s_axis_tkeep  = {8{seq[7:0]}};
        s_axis_tid    = seq[5:0];
        s_axis_tlast  = last;
    endtask

    task automatic put_beat(input int seq, input logic last, input logic [13:0] tag,
                            input logic cfg_v, input logic [13:0] cfg);
        int   t;
        exp_t e;
        t = 0;
        set_beat(seq, last);
        route_cfg       = cfg;
        route_cfg_valid = cfg_v;
        @(negedge aclk);
        while (!s_axis_tready && t < 200) begin
            @(posedge aclk);
            #1;
            route_cfg_valid = 1'b0;
            @(negedge aclk);
            t++;
        end
        if (!s_axis_tready)
            check("accept_timeout", 64'(s_axis_tready), 64'd1);
        else begin
            e.seq  = 32'(seq);
            e.last = last;
            e.tag  = tag;
            exp_q.push_back(e);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid   = 1'b0;
        route_cfg_valid = 1'b0;
    endtask

    task automatic cfg_strobe(input logic [13:0] r);
        route_cfg       = r;
        route_cfg_valid = 1'b1;
        @(posedge aclk);
        #1;
        route_cfg_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int viol, a0, sent, pk, rx0, len;
        repeat (2) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_cfg_applied", 64'(cfg_applied), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_route_act", 64'(route_act), 64'h0BFC);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        areset = 1'b0;

        // No route yet: input held off, nothing forwarded.
        set_beat(1, 1'b1);
        viol = 0;
        repeat (20) begin
            @(negedge aclk);
            if (s_axis_tready || m_axis_tvalid)
                viol++;
        end
        check("no_cfg_blocked", 64'(viol), 64'd0);
        @(posedge aclk);
        #1;
        cfg_strobe(14'h0FFC);
        check("first_apply_pulse", 64'(cfg_applied), 64'd1);
        check("first_route_act", 64'(route_act), 64'h0FFC);
        check("first_s_tready", 64'(s_axis_tready), 64'd1);
        exp_q.push_back('{seq: 32'd1, last: 1'b1, tag: 14'h0FFC});
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        check("first_pulse_once", 64'(cfg_applied), 64'd0);
        check("first_latency", 64'(m_axis_tvalid), 64'd1);
        drain();
        check("pkt_cnt_1", 64'(pkt_cnt), 64'd1);

        // 4-beat packet on 0x0AAA with one-cycle latency.
        cfg_strobe(14'h0AAA);
        check("idle_apply", 64'(route_act), 64'h0AAA);
        put_beat(10, 1'b0, 14'h0AAA, 1'b0, 14'h0);
        check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("latency_tdest", 64'(m_axis_tdest), 64'h0AAA);
        for (int i = 11; i <= 13; i++)
            put_beat(i, i == 13, 14'h0AAA, 1'b0, 14'h0);
        drain();
        check("pkt_cnt_2", 64'(pkt_cnt), 64'd2);

        // Strobe on beat 2 of 8 is deferred to the packet's tlast.
        a0 = n_applied;
        for (int i = 0; i < 8; i++) begin
            put_beat(20 + i, i == 7, 14'h0AAA, i == 1, 14'h0BBB);
            if (i == 6)
                check("mid_pkt_hold", 64'(route_act), 64'h0AAA);
        end
        check("tlast_apply_pulse", 64'(cfg_applied), 64'd1);
        check("tlast_apply_route", 64'(route_act), 64'h0BBB);
        put_beat(30, 1'b0, 14'h0BBB, 1'b0, 14'h0);
        put_beat(31, 1'b1, 14'h0BBB, 1'b0, 14'h0);
        drain();
        check("applied_once_3", 64'(n_applied - a0), 64'd1);
        check("pkt_cnt_4", 64'(pkt_cnt), 64'd4);

        // Two strobes in one packet: last one wins, single apply.
        a0 = n_applied;
        for (int i = 0; i < 4; i++)
            put_beat(40 + i, i == 3, 14'h0BBB, i == 0 || i == 2, i == 0 ? 14'h0111 : 14'h0222);
        check("double_cfg_route", 64'(route_act), 64'h0222);
        for (int i = 50; i <= 52; i++)
            put_beat(i, i == 52, 14'h0222, 1'b0, 14'h0);
        drain();
        check("applied_once_4", 64'(n_applied - a0), 64'd1);
        check("pkt_cnt_6", 64'(pkt_cnt), 64'd6);

        // Random output back-pressure over 1000 beats.
        rnd  = 1'b1;
        sent = 0;
        pk   = 0;
        rx0  = n_rx;
        while (sent < 1000) begin
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) begin
                put_beat(1000 + sent, j == len - 1, 14'h0222, 1'b0, 14'h0);
                sent++;
            end
            pk++;
        end
        rnd = 1'b0;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        drain();
        check("rand_pkt_cnt", 64'(pkt_cnt), 64'(6 + pk));
        check("rand_beats", 64'(n_rx - rx0), 64'(sent));

        // Reset with two beats buffered mid-packet.
        m_axis_tready = 1'b0;
        put_beat(60, 1'b0, 14'h0222, 1'b0, 14'h0);
        put_beat(61, 1'b0, 14'h0222, 1'b0, 14'h0);
        check("full_s_tready", 64'(s_axis_tready), 64'd0);
        check("full_m_tvalid", 64'(m_axis_tvalid), 64'd1);
        areset = 1'b1;
        @(posedge aclk);
        #1;
        check("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("mid_rst_route_act", 64'(route_act), 64'h0BFC);
        check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("mid_rst_cfg_applied", 64'(cfg_applied), 64'd0);
        exp_q.delete();
        areset = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        check("post_rst_empty", 64'(m_axis_tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
